std_arbiter: RTL and testbench

STD_ARBITER -- requirements
Module: std_arbiter

---
 rtl/std_arbiter.sv | 112 +++++++++++
 tb/tb_std_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/std_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : std_arbiter
// Brief    : Packet-aware round-robin arbiter; locks onto a source until its
//            last beat, with a single registered output stage.
// Revision : 1.0 - initial release
// ============================================================================
module std_arbiter #(
    parameter int  NUM_INPUTS = 4,
    parameter int  DATA_WIDTH = 32,
    localparam int ID_WIDTH   = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_INPUTS-1:0]            valid_input,
    output logic [NUM_INPUTS-1:0]            ready_input,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] data_input,
    input  logic [NUM_INPUTS-1:0]            last_input,
    output logic                             valid_output,
    input  logic                             ready_output,
    output logic [DATA_WIDTH-1:0]            data_output,
    output logic                             last_output,
    output logic [ID_WIDTH-1:0]              id_output
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]            r_mode;
    logic [ID_WIDTH-1:0]   r_lock;
    logic [ID_WIDTH-1:0]   r_ptr;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_last;
    logic [ID_WIDTH-1:0]   r_id;

    logic                  w_enable;
    logic                  w_gnt_any;
    logic [ID_WIDTH-1:0]   w_gnt;
    logic                  w_xfer;
    logic                  w_gnt_last;
    logic [DATA_WIDTH-1:0] w_gnt_data;

    // (base + off) mod NUM_INPUTS, with base < NUM_INPUTS and off <= NUM_INPUTS
    function automatic logic [ID_WIDTH-1:0] rr_index(input logic [ID_WIDTH-1:0] base,
                                                     input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_INPUTS) s = s - NUM_INPUTS;
        return ID_WIDTH'(s);
    endfunction

    assign w_enable = !rst && (!r_valid || ready_output);

    // Descending scan so the candidate closest to the pointer is assigned last and wins
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt     = '0;
        if (r_mode == ST_LOCKED) begin
            w_gnt_any = 1'b1;
            w_gnt     = r_lock;
        end else begin
            for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
                if (valid_input[rr_index(r_ptr, k)]) begin
                    w_gnt_any = 1'b1;
                    w_gnt     = rr_index(r_ptr, k);
                end
            end
        end
    end

    assign w_gnt_data = data_input[int'(w_gnt)*DATA_WIDTH +: DATA_WIDTH];
    assign w_gnt_last = last_input[w_gnt];
    assign w_xfer     = w_enable && w_gnt_any && valid_input[w_gnt];

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_ready
        assign ready_input[i] = w_enable && w_gnt_any && (w_gnt == ID_WIDTH'(i));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode  <= ST_IDLE;
            r_lock  <= '0;
            r_ptr   <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
            r_id    <= '0;
        end else if (w_xfer) begin
            r_valid <= 1'b1;
            r_data  <= w_gnt_data;
            r_last  <= w_gnt_last;
            r_id    <= w_gnt;
            if (w_gnt_last) begin
                r_mode <= ST_IDLE;
                r_ptr  <= rr_index(w_gnt, 1);
            end else begin
                r_mode <= ST_LOCKED;
                r_lock <= w_gnt;
            end
        end else if (ready_output) begin
            r_valid <= 1'b0;
        end
    end

    assign valid_output = r_valid;
    assign data_output  = r_data;
    assign last_output  = r_last;
    assign id_output    = r_id;

endmodule
`default_nettype wire

// File: tb/tb_std_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_std_arbiter
// Brief    : Randomized scoreboard bench for std_arbiter with a packet-level
//            reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_std_arbiter;

    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int IDW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    valid_input = '0;
    logic [N-1:0]    ready_input;
    logic [N*DW-1:0] data_input;
    logic [N-1:0]    last_input = '0;
    logic            valid_output;
    logic            ready_output = 1'b0;
    logic [DW-1:0]   data_output;
    logic            last_output;
    logic [IDW-1:0]  id_output;

    logic [DW-1:0]   din [N];

    for (genvar i = 0; i < N; i++) begin : g_flat
        assign data_input[i*DW +: DW] = din[i];
    end

    std_arbiter #(.NUM_INPUTS(N), .DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_input (valid_input),
        .ready_input (ready_input),
        .data_input  (data_input),
        .last_input  (last_input),
        .valid_output(valid_output),
        .ready_output(ready_output),
        .data_output (data_output),
        .last_output (last_output),
        .id_output   (id_output)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected beats, {data, last, id}, oldest first
    logic [DW+IDW:0] sb [$];

    // Reference model: packet ownership and fairness pointer, plus output occupancy
    bit  m_locked = 0;
    int  m_owner  = 0;
    int  m_next   = 0;
    bit  m_full   = 0;

    task automatic drive_cycle(input bit rst_v, input int pv, input int pl, input int pr);
        int          g;
        bit          have;
        bit          en;
        logic [N-1:0] exp_ready;
        @(posedge clk);
        #1;
        rst = rst_v;
        for (int i = 0; i < N; i++) begin
            valid_input[i] = ($urandom_range(99) < pv);
            last_input[i]  = ($urandom_range(99) < pl);
            din[i]         = $urandom;
        end
        ready_output = ($urandom_range(99) < pr);
        #2;
        if (rst) begin
            checks++;
            if (ready_input !== '0) begin
                errors++;
                $display("FAIL reset_ready: got %b expected 0000", ready_input);
            end
            sb.delete();
            m_locked = 0; m_owner = 0; m_next = 0; m_full = 0;
        end else begin
            checks++;
            if (valid_output !== m_full) begin
                errors++;
                $display("FAIL valid_output: got %b expected %b", valid_output, m_full);
            end
            en   = !m_full || ready_output;
            have = 0;
            g    = 0;
            if (m_locked) begin
                have = 1;
                g    = m_owner;
            end else begin
                for (int k = 0; k < N; k++) begin
                    if (!have && valid_input[(m_next + k) % N]) begin
                        have = 1;
                        g    = (m_next + k) % N;
                    end
                end
            end
            exp_ready = (en && have) ? N'(1 << g) : '0;
            checks++;
            if (ready_input !== exp_ready) begin
                errors++;
                $display("FAIL ready_input: got %b expected %b", ready_input, exp_ready);
            end
            if (en && have && valid_input[g]) begin
                sb.push_back({din[g], last_input[g], IDW'(g)});
                m_full = 1;
                if (last_input[g]) begin
                    m_locked = 0;
                    m_next   = (g + 1) % N;
                end else begin
                    m_locked = 1;
                    m_owner  = g;
                end
            end else if (ready_output) begin
                m_full = 0;
            end
        end
    endtask

    // Monitor: consumes presented beats and checks stall stability
    initial begin
        logic [DW+IDW:0] prev_beat;
        logic [DW+IDW:0] exp;
        bit              prev_stall;
        prev_stall = 0;
        prev_beat  = '0;
        forever begin
            @(negedge clk);
            if (prev_stall) begin
                checks++;
                if (!valid_output || {data_output, last_output, id_output} !== prev_beat) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%b %h expected v=1 %h", valid_output,
                             {data_output, last_output, id_output}, prev_beat);
                end
            end
            prev_stall = 0;
            if (!rst && valid_output) begin
                if (ready_output) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL beat_unexpected: got id=%0d data=%h expected none",
                                 id_output, data_output);
                    end else begin
                        exp = sb.pop_front();
                        if ({data_output, last_output, id_output} !== exp) begin
                            errors++;
                            $display("FAIL beat: got data=%h last=%b id=%0d expected data=%h last=%b id=%0d",
                                     data_output, last_output, id_output,
                                     exp[DW+IDW:IDW+1], exp[IDW], exp[IDW-1:0]);
                        end
                    end
                end else begin
                    prev_stall = 1;
                    prev_beat  = {data_output, last_output, id_output};
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) din[i] = '0;
        repeat (3) drive_cycle(1'b1, 0, 0, 0);
        checks++;
        if (valid_output !== 1'b0 || data_output !== '0 || last_output !== 1'b0 || id_output !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b d=%h l=%b id=%0d expected all zero",
                     valid_output, data_output, last_output, id_output);
        end
        // All sources streaming single-beat packets: fair rotation 0,1,2,3,0
        repeat (6) drive_cycle(1'b0, 100, 100, 100);
        // Multi-beat packets with gaps and backpressure
        repeat (400) drive_cycle(1'b0, 60, 30, 70);
        // Heavy output stall
        repeat (200) drive_cycle(1'b0, 70, 40, 20);
        // Occasional mid-stream resets
        for (int c = 0; c < 600; c++)
            drive_cycle($urandom_range(99) < 2, 55, 35, 75);
        // Sparse traffic exercising pointer wrap
        repeat (300) drive_cycle(1'b0, 15, 80, 90);
        // Drain
        repeat (6) drive_cycle(1'b0, 0, 0, 100);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d beats left expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
